// File: rtl/muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// muldiv_unit_if -- request/result bundle for the multiply/divide unit.
//
//   start     request pulse, sampled only while the unit is idle
//   op        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op1/op2   multiplicand/dividend and multiplier/divisor
//   write_hi  direct load of hi from wdata (MTHI)
//   write_lo  direct load of lo from wdata (MTLO)
//   wdata     data for write_hi/write_lo
//   hi/lo     architectural HI/LO registers
//   busy      high whenever an operation is in flight
//   done      one-cycle pulse when hi/lo take a new result
//
// master: the requester (pipeline or testbench); slave: the unit.
// ---------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             write_hi;
    logic             write_lo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, op1, op2, write_hi, write_lo, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, op1, op2, write_hi, write_lo, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit -- iterative MIPS-style multiply/divide unit with HI/LO.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    muldiv_unit_if.slave (start/op/op1/op2/write_hi/write_lo/wdata in,
//          hi/lo/busy/done out)
//
// One operation takes WIDTH+2 edges: capture (IDLE), WIDTH iterations (RUN),
// and a result write (FINISH). Signed operations run on magnitudes and fix
// the signs when the result is written.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    // arg: multiplicand (multiply) or divisor (divide) magnitude.
    // {acc, q}: product accumulator / remainder:quotient shift pair.
    logic [WIDTH-1:0] arg, acc, q;
    logic             is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0] hi_r, lo_r;
    logic             done_r;

    logic             accept, write_ok;
    logic             is_signed, sign1, sign2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH:0]   mul_sum, div_shift;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] acc_nxt, q_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // ---------------- state register ----------------
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)    state_nxt = RUN;
            RUN:     if (cnt == LAST)  state_nxt = FINISH;
            FINISH:                    state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        bus.busy = (state != IDLE);
        accept   = (state == IDLE) && bus.start;
        // start wins over a register write in the same idle cycle.
        write_ok = (state == IDLE) && !bus.start;
    end

    // ---------------- operand capture ----------------
    always_comb begin
        is_signed = ~bus.op[0];
        sign1     = is_signed & bus.op1[WIDTH-1];
        sign2     = is_signed & bus.op2[WIDTH-1];
        mag1      = sign1 ? -bus.op1 : bus.op1;
        mag2      = sign2 ? -bus.op2 : bus.op2;
    end

    // ---------------- one iteration ----------------
    always_comb begin
        // Shift-add: add the multiplicand when the multiplier LSB is set,
        // then shift the whole {carry, acc, q} right by one.
        mul_sum   = {1'b0, acc} + (q[0] ? {1'b0, arg} : '0);
        // Restoring divide: shift the next dividend bit into the remainder
        // and subtract the divisor if it fits.
        div_shift = {acc, q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, arg});
        // When div_ge holds the true difference is below arg, so it fits.
        div_diff  = div_shift[WIDTH-1:0] - arg;
        if (is_div) begin
            acc_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
            q_nxt   = {q[WIDTH-2:0], div_ge};
        end else begin
            acc_nxt = mul_sum[WIDTH:1];
            q_nxt   = {mul_sum[0], q[WIDTH-1:1]};
        end
    end

    // ---------------- result sign fix-up ----------------
    always_comb begin
        prod_fix = neg_q ? -{acc, q} : {acc, q};
        // A zero divisor leaves the dividend magnitude in acc, so the usual
        // remainder sign fix already reproduces op1; only lo is forced.
        quo_fix  = div_zero ? '1 : (neg_q ? -q : q);
        rem_fix  = neg_r ? -acc : acc;
    end

    // ---------------- datapath and HI/LO ----------------
    // NOTE: every datapath flop is reset with the control so an aborted
    // operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            arg      <= '0;
            acc      <= '0;
            q        <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt      <= '0;
                        is_div   <= bus.op[1];
                        arg      <= bus.op[1] ? mag2 : mag1;
                        q        <= bus.op[1] ? mag1 : mag2;
                        acc      <= '0;
                        neg_q    <= sign1 ^ sign2;
                        neg_r    <= sign1;
                        div_zero <= (bus.op2 == '0);
                    end
                    if (write_ok && bus.write_hi) hi_r <= bus.wdata;
                    if (write_ok && bus.write_lo) lo_r <= bus.wdata;
                end
                RUN: begin
                    acc <= acc_nxt;
                    q   <= q_nxt;
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    done_r <= 1'b1;
                    if (is_div) begin
                        hi_r <= rem_fix;
                        lo_r <= quo_fix;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit -- self-checking bench for muldiv_unit (WIDTH=32).
// Directed cases with fixed expected values, plus random operations checked
// against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, sq, sr;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    return {sr[31:0], sq[31:0]};
                end
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE and wait for done. Returns in the done
    // cycle, so a following call exercises back-to-back issue. With disturb
    // set, start/write_hi/write_lo are held high while busy.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input bit disturb, input string tag);
        logic [63:0] held;
        int          lat;
        int          hold_err;
        held      = {bus.hi, bus.lo};
        bus.start = 1'b1;
        bus.op    = op;
        bus.op1   = a;
        bus.op2   = b;
        tick();
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat      = 1;
        hold_err = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            bus.start    = disturb;
            bus.op       = 2'($urandom);
            bus.op1      = $urandom;
            bus.op2      = $urandom;
            bus.write_hi = disturb;
            bus.write_lo = disturb;
            bus.wdata    = 32'h1234_5678;
            if ({bus.hi, bus.lo} !== held) hold_err++;
            tick();
            lat++;
        end
        bus.start    = 1'b0;
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_hilo_hold"}, 64'(hold_err), 64'd0);
        check({tag, "_hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, "_lo"}, 64'(bus.lo), 64'(exp[31:0]));
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;
        int          cyc, last, nd, dcount;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.op1      = '0;
        bus.op2      = '0;
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        bus.wdata    = '0;
        #3;
        check("reset_hi",   64'(bus.hi),   64'd0);
        check("reset_lo",   64'(bus.lo),   64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed arithmetic cases, issued back to back.
        run_op(2'b00, 32'hFFFF_FFFE, 32'h0000_0003, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 1'b0, "mult_m2x3");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, "div_m7by2");
        run_op(2'b11, 32'h0000_0007, 32'h0000_0000, {32'h0000_0007, 32'hFFFF_FFFF}, 1'b0, "divu_by0");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b0, "div_ovf");
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0000, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0, "div_neg_by0");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, {32'h4000_0000, 32'h0000_0000}, 1'b0, "mult_minsq");

        // Register writes in IDLE: same edge, no done pulse.
        bus.write_lo = 1'b1;
        bus.wdata    = 32'h1234_5678;
        tick();
        bus.write_lo = 1'b0;
        check("mtlo_lo",   64'(bus.lo),   64'h1234_5678);
        check("mtlo_done", 64'(bus.done), 64'd0);
        bus.write_hi = 1'b1;
        bus.write_lo = 1'b1;
        bus.wdata    = 32'hA5A5_0F0F;
        tick();
        bus.write_hi = 1'b0;
        bus.write_lo = 1'b0;
        check("mthilo_hi",   64'(bus.hi),   64'hA5A5_0F0F);
        check("mthilo_lo",   64'(bus.lo),   64'hA5A5_0F0F);
        check("mthilo_done", 64'(bus.done), 64'd0);

        // start and a write in the same idle cycle: start wins.
        bus.write_hi = 1'b1;
        bus.write_lo = 1'b1;
        bus.wdata    = 32'hDEAD_BEEF;
        run_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, "start_wins");

        // Writes and start held high while busy are ignored.
        run_op(2'b11, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b1, "busy_writes");
        tick();
        check("single_done", 64'(bus.done), 64'd0);

        // start held high: one MULTU 2*3 every 34 cycles, operands
        // scrambled while busy and restored in the done cycle.
        bus.op    = 2'b01;
        bus.op1   = 32'd2;
        bus.op2   = 32'd3;
        bus.start = 1'b1;
        cyc  = 0;
        last = 0;
        nd   = 0;
        while (nd < 3 && cyc < 200) begin
            tick();
            cyc++;
            if (bus.done === 1'b1) begin
                check("b2b_period", 64'(cyc - last), 64'd34);
                check("b2b_lo", 64'(bus.lo), 64'd6);
                check("b2b_hi", 64'(bus.hi), 64'd0);
                last    = cyc;
                nd++;
                bus.op  = 2'b01;
                bus.op1 = 32'd2;
                bus.op2 = 32'd3;
            end else if (bus.busy === 1'b1) begin
                bus.op  = 2'($urandom);
                bus.op1 = $urandom;
                bus.op2 = $urandom;
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 64'(nd), 64'd3);
        tick();

        // Reset in the middle of a MULTU aborts it.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.op1   = 32'hFFFF_FFFF;
        bus.op2   = 32'hFFFF_FFFF;
        tick();
        bus.start = 1'b0;
        repeat (9) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_hi",   64'(bus.hi),   64'd0);
        check("abort_lo",   64'(bus.lo),   64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) dcount++;
        end
        check("abort_no_done", 64'(dcount), 64'd0);
        check("abort_hi_kept", 64'(bus.hi), 64'd0);
        run_op(2'b01, 32'd6, 32'd7, {32'd0, 32'h0000_002A}, 1'b0, "multu_6x7");

        // Random operations against the reference model.
        for (int i = 0; i < 24; i++) begin
            r_op = 2'($urandom);
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 3))
                0: r_b = 32'($urandom_range(0, 5));
                1: r_b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
